dbg_capture_ctrl: RTL and testbench

- On-chip capture sequencer for DDR3 test debug signals: error, error1, u_rd error flag, init_calib_complete.
- Records a trigger-centred window of samples into an internal ring buffer on clk_x1.
- Buffer is read out sequentially afterwards through a simple request/valid port.
- Sits beside the DDR3 traffic checker; used when the JTAG analyzer is unavailable or a fixed-window capture is needed.

---
 rtl/dbg_capture_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_dbg_capture_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dbg_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dbg_capture_ctrl
// Purpose  : Trigger-centred capture of debug probes into a ring buffer, with
//            sequential request/valid readout. Optional macro:
//            DBG_CAP_TRIG_CNT_EN (trigger on the N-th qualifying cycle).
// Revision : 1.0 - initial release
// ============================================================================
module dbg_capture_ctrl #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 4
) (
    input  logic              clk_x1,
    input  logic              rst,
    input  logic              arm_i,
    input  logic              abort_i,
    input  logic [ADDR_W-1:0] pre_len_i,
    input  logic              trig_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              rd_req_i,
`ifdef DBG_CAP_TRIG_CNT_EN
    input  logic [7:0]        trig_cnt_i,
    output logic [7:0]        trig_hits_o,
`endif
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_valid_o,
    output logic              rd_last_o,
    output logic [ADDR_W-1:0] trig_addr_o,
    output logic              done_o,
    output logic [2:0]        state_o
);

    localparam int c_depth = 2 ** ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_ARMED = 3'd2,
        S_POST  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DATA_W-1:0] r_mem [c_depth];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_fill_cnt;
    logic [ADDR_W-1:0] r_pre_q;
    logic [ADDR_W-1:0] r_post_cnt;
    logic [ADDR_W-1:0] r_trig_addr;
    logic [ADDR_W:0]   r_rd_cnt;
    logic              r_rd_valid;
    logic              r_rd_last;
    logic [DATA_W-1:0] r_rd_data;
    logic              w_wr_en;
    logic              w_trig_fire;
    logic              w_rd_fire;
    logic [ADDR_W-1:0] w_fill_inc;
    logic [ADDR_W-1:0] w_rd_addr;

    assign w_fill_inc = r_fill_cnt + 1'b1;
    // Oldest sample of the window sits pre_q entries behind the trigger.
    assign w_rd_addr  = r_trig_addr - r_pre_q + r_rd_cnt[ADDR_W-1:0];

`ifdef DBG_CAP_TRIG_CNT_EN
    logic [7:0] r_trig_cnt_q;
    logic [7:0] r_trig_hits;

    assign w_trig_fire = trig_i && (r_trig_hits == r_trig_cnt_q);
    assign trig_hits_o = r_trig_hits;

    always_ff @(posedge clk_x1) begin
        if (rst) begin
            r_trig_cnt_q <= '0;
            r_trig_hits  <= '0;
        end else if (abort_i) begin
            r_trig_hits  <= r_trig_hits;
        end else if (arm_i) begin
            r_trig_cnt_q <= trig_cnt_i;
            r_trig_hits  <= '0;
        end else if (r_state == S_ARMED && trig_i) begin
            r_trig_hits  <= r_trig_hits + 8'd1;
        end
    end
`else
    assign w_trig_fire = trig_i;
`endif

    always_ff @(posedge clk_x1) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_wr_en     = 1'b0;
        w_rd_fire   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_IDLE;
            end
            S_FILL: begin
                if (r_pre_q == '0) begin
                    w_state_nxt = S_ARMED;
                end else begin
                    w_wr_en = 1'b1;
                    if (w_fill_inc == r_pre_q) begin
                        w_state_nxt = S_ARMED;
                    end
                end
            end
            S_ARMED: begin
                w_wr_en = 1'b1;
                if (w_trig_fire) begin
                    // A full pre-window leaves no post samples to take.
                    w_state_nxt = (&r_pre_q) ? S_DONE : S_POST;
                end
            end
            S_POST: begin
                w_wr_en = 1'b1;
                if (r_post_cnt == ADDR_W'(1)) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_rd_fire = rd_req_i && !r_rd_cnt[ADDR_W];
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        if (arm_i) begin
            w_state_nxt = S_FILL;
            w_wr_en     = 1'b0;
            w_rd_fire   = 1'b0;
        end
        if (abort_i) begin
            w_state_nxt = S_IDLE;
            w_wr_en     = 1'b0;
            w_rd_fire   = 1'b0;
        end
    end

    always_ff @(posedge clk_x1) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

    always_ff @(posedge clk_x1) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_fill_cnt  <= '0;
            r_pre_q     <= '0;
            r_post_cnt  <= '0;
            r_trig_addr <= '0;
            r_rd_cnt    <= '0;
            r_rd_valid  <= 1'b0;
            r_rd_last   <= 1'b0;
            r_rd_data   <= '0;
        end else if (abort_i) begin
            r_rd_cnt    <= '0;
            r_rd_valid  <= 1'b0;
            r_rd_last   <= 1'b0;
        end else if (arm_i) begin
            r_wr_ptr    <= '0;
            r_fill_cnt  <= '0;
            r_pre_q     <= pre_len_i;
            r_rd_cnt    <= '0;
            r_rd_valid  <= 1'b0;
            r_rd_last   <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_fire;
            r_rd_last  <= w_rd_fire && (&r_rd_cnt[ADDR_W-1:0]);
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (r_state == S_FILL && w_wr_en) begin
                r_fill_cnt <= w_fill_inc;
            end
            if (r_state == S_ARMED && w_trig_fire) begin
                r_trig_addr <= r_wr_ptr;
                r_post_cnt  <= ~r_pre_q;
            end
            if (r_state == S_POST) begin
                r_post_cnt <= r_post_cnt - 1'b1;
            end
            if (w_rd_fire) begin
                r_rd_data <= r_mem[w_rd_addr];
                r_rd_cnt  <= r_rd_cnt + 1'b1;
            end
        end
    end

    assign rd_data_o   = r_rd_data;
    assign rd_valid_o  = r_rd_valid;
    assign rd_last_o   = r_rd_last;
    assign trig_addr_o = r_trig_addr;
    assign done_o      = (r_state == S_DONE);
    assign state_o     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_dbg_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dbg_capture_ctrl
// Purpose  : Directed self-checking bench for dbg_capture_ctrl (DEPTH=16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dbg_capture_ctrl;

    logic       clk_x1 = 1'b0;
    logic       rst = 1'b1;
    logic       arm_i = 1'b0;
    logic       abort_i = 1'b0;
    logic [3:0] pre_len_i = 4'd0;
    logic       trig_i = 1'b0;
    logic [3:0] data_i = 4'd0;
    logic       rd_req_i = 1'b0;
    logic [3:0] rd_data_o;
    logic       rd_valid_o;
    logic       rd_last_o;
    logic [3:0] trig_addr_o;
    logic       done_o;
    logic [2:0] state_o;
`ifdef DBG_CAP_TRIG_CNT_EN
    logic [7:0] trig_cnt_i = 8'd0;
    logic [7:0] trig_hits_o;
`endif

    int n_checks = 0;
    int n_fail = 0;

    logic [3:0] cap_data  [16];
    logic       cap_valid [16];
    logic       cap_last  [16];
    logic [3:0] trig_val;

    dbg_capture_ctrl #(.DATA_W(4), .ADDR_W(4)) dut (
        .clk_x1      (clk_x1),
        .rst         (rst),
        .arm_i       (arm_i),
        .abort_i     (abort_i),
        .pre_len_i   (pre_len_i),
        .trig_i      (trig_i),
        .data_i      (data_i),
        .rd_req_i    (rd_req_i),
`ifdef DBG_CAP_TRIG_CNT_EN
        .trig_cnt_i  (trig_cnt_i),
        .trig_hits_o (trig_hits_o),
`endif
        .rd_data_o   (rd_data_o),
        .rd_valid_o  (rd_valid_o),
        .rd_last_o   (rd_last_o),
        .trig_addr_o (trig_addr_o),
        .done_o      (done_o),
        .state_o     (state_o)
    );

    always #5 clk_x1 = ~clk_x1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // The sample bus advances once per cycle; inputs change 1 ns after the edge.
    task automatic tick();
        @(posedge clk_x1);
        #1;
        data_i = data_i + 4'd1;
    endtask

    task automatic arm(input logic [3:0] pre);
        pre_len_i = pre;
        arm_i = 1'b1;
        tick();
        arm_i = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] s, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (state_o == s) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic fire_trigger();
        trig_i = 1'b1;
        trig_val = data_i;
        tick();
        trig_i = 1'b0;
    endtask

    task automatic collect(input int n);
        rd_req_i = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick();
            cap_valid[i] = rd_valid_o;
            cap_data[i]  = rd_data_o;
            cap_last[i]  = rd_last_o;
        end
        rd_req_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_checks++; if (state_o !== 3'd0) begin n_fail++; $display("FAIL reset_state got=%0d exp=0", state_o); end
        n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done_o); end
        n_checks++; if (rd_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", rd_valid_o); end
        n_checks++; if (rd_last_o !== 1'b0) begin n_fail++; $display("FAIL reset_last got=%b exp=0", rd_last_o); end
        n_checks++; if (rd_data_o !== 4'd0) begin n_fail++; $display("FAIL reset_data got=%0d exp=0", rd_data_o); end
        n_checks++; if (trig_addr_o !== 4'd0) begin n_fail++; $display("FAIL reset_trig_addr got=%0d exp=0", trig_addr_o); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic_window();
        bit ok;
        logic [3:0] e;
        for (int i = 0; i < 20; i++) begin
            if (data_i == 4'd4) break;
            tick();
        end
        arm(4'd4);
        n_checks++; if (state_o !== 3'd1) begin n_fail++; $display("FAIL basic_fill_state got=%0d exp=1", state_o); end
        wait_state(3'd2, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL basic_armed_timeout got=%0d exp=2", state_o); end
        fire_trigger();
        n_checks++; if (state_o !== 3'd3) begin n_fail++; $display("FAIL basic_post_state got=%0d exp=3", state_o); end
        wait_state(3'd4, ok);
        n_checks++; if (!ok || done_o !== 1'b1) begin n_fail++; $display("FAIL basic_done got=%b exp=1", done_o); end
        n_checks++; if (trig_addr_o !== 4'd4) begin n_fail++; $display("FAIL basic_trig_addr got=%0d exp=4", trig_addr_o); end
        rd_req_i = 1'b1;
        tick();
        rd_req_i = 1'b0;
        e = trig_val - 4'd4;
        n_checks++; if (rd_valid_o !== 1'b1 || rd_data_o !== e || rd_last_o !== 1'b0) begin
            n_fail++; $display("FAIL basic_first_sample got=v%b d%0d l%b exp=v1 d%0d l0", rd_valid_o, rd_data_o, rd_last_o, e); end
        tick();
        n_checks++; if (rd_valid_o !== 1'b0) begin n_fail++; $display("FAIL basic_valid_one_cycle got=%b exp=0", rd_valid_o); end
        collect(15);
        for (int k = 0; k < 15; k++) begin
            e = trig_val - 4'd4 + 4'(k + 1);
            n_checks++; if (cap_valid[k] !== 1'b1 || cap_data[k] !== e || cap_last[k] !== (k == 14)) begin
                n_fail++; $display("FAIL basic_sample_%0d got=v%b d%0d l%b exp=v1 d%0d l%0d", k + 1, cap_valid[k], cap_data[k], cap_last[k], e, (k == 14)); end
        end
        tick();
        n_checks++; if (rd_valid_o !== 1'b0 || rd_last_o !== 1'b0) begin n_fail++; $display("FAIL basic_stream_end got=v%b l%b exp=v0 l0", rd_valid_o, rd_last_o); end
        rd_req_i = 1'b1;
        tick();
        rd_req_i = 1'b0;
        n_checks++; if (rd_valid_o !== 1'b0) begin n_fail++; $display("FAIL basic_exhausted_req got=%b exp=0", rd_valid_o); end
    endtask

    task automatic test_pre_zero();
        bit ok;
        logic [3:0] e;
        arm(4'd0);
        wait_state(3'd2, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL pre0_armed_timeout got=%0d exp=2", state_o); end
        fire_trigger();
        wait_state(3'd4, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL pre0_done_timeout got=%0d exp=4", state_o); end
        n_checks++; if (trig_addr_o !== 4'd0) begin n_fail++; $display("FAIL pre0_trig_addr got=%0d exp=0", trig_addr_o); end
        collect(16);
        for (int k = 0; k < 16; k++) begin
            e = trig_val + 4'(k);
            n_checks++; if (cap_valid[k] !== 1'b1 || cap_data[k] !== e || cap_last[k] !== (k == 15)) begin
                n_fail++; $display("FAIL pre0_sample_%0d got=v%b d%0d l%b exp=v1 d%0d l%0d", k, cap_valid[k], cap_data[k], cap_last[k], e, (k == 15)); end
        end
    endtask

    task automatic test_wrap();
        bit ok;
        logic [3:0] e;
        arm(4'd15);
        wait_state(3'd2, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL wrap_armed_timeout got=%0d exp=2", state_o); end
        repeat (40) tick();
        n_checks++; if (state_o !== 3'd2) begin n_fail++; $display("FAIL wrap_still_armed got=%0d exp=2", state_o); end
        fire_trigger();
        n_checks++; if (state_o !== 3'd4 || done_o !== 1'b1) begin n_fail++; $display("FAIL wrap_direct_done got=s%0d d%b exp=s4 d1", state_o, done_o); end
        n_checks++; if (trig_addr_o !== 4'd7) begin n_fail++; $display("FAIL wrap_trig_addr got=%0d exp=7", trig_addr_o); end
        collect(16);
        for (int k = 0; k < 16; k++) begin
            e = trig_val - 4'd15 + 4'(k);
            n_checks++; if (cap_valid[k] !== 1'b1 || cap_data[k] !== e || cap_last[k] !== (k == 15)) begin
                n_fail++; $display("FAIL wrap_sample_%0d got=v%b d%0d l%b exp=v1 d%0d l%0d", k, cap_valid[k], cap_data[k], cap_last[k], e, (k == 15)); end
        end
    endtask

    task automatic test_abort();
        bit ok;
        arm(4'd4);
        wait_state(3'd2, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL abort_armed_timeout got=%0d exp=2", state_o); end
        fire_trigger();
        n_checks++; if (state_o !== 3'd3) begin n_fail++; $display("FAIL abort_pre_post got=%0d exp=3", state_o); end
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        n_checks++; if (state_o !== 3'd0 || done_o !== 1'b0) begin n_fail++; $display("FAIL abort_in_post got=s%0d d%b exp=s0 d0", state_o, done_o); end
        arm_i = 1'b1;
        abort_i = 1'b1;
        tick();
        arm_i = 1'b0;
        abort_i = 1'b0;
        n_checks++; if (state_o !== 3'd0) begin n_fail++; $display("FAIL abort_over_arm got=%0d exp=0", state_o); end
        tick();
        n_checks++; if (state_o !== 3'd0) begin n_fail++; $display("FAIL abort_stays_idle got=%0d exp=0", state_o); end
    endtask

    task automatic test_gating_and_reset();
        bit ok;
        int seen;
        logic [3:0] e;
        arm(4'd4);
        wait_state(3'd2, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL gate_armed_timeout got=%0d exp=2", state_o); end
        seen = 0;
        rd_req_i = 1'b1;
        repeat (3) begin
            tick();
            if (rd_valid_o !== 1'b0) seen++;
        end
        rd_req_i = 1'b0;
        n_checks++; if (seen != 0) begin n_fail++; $display("FAIL gate_req_in_armed got=%0d valid cycles exp=0", seen); end
        fire_trigger();
        wait_state(3'd4, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL gate_done_timeout got=%0d exp=4", state_o); end
        collect(5);
        for (int k = 0; k < 5; k++) begin
            e = trig_val - 4'd4 + 4'(k);
            n_checks++; if (cap_valid[k] !== 1'b1 || cap_data[k] !== e) begin
                n_fail++; $display("FAIL gate_partial_%0d got=v%b d%0d exp=v1 d%0d", k, cap_valid[k], cap_data[k], e); end
        end
        rst = 1'b1;
        rd_req_i = 1'b1;
        tick();
        n_checks++; if (state_o !== 3'd0 || done_o !== 1'b0 || rd_valid_o !== 1'b0 || rd_last_o !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_read got=s%0d d%b v%b l%b exp=s0 d0 v0 l0", state_o, done_o, rd_valid_o, rd_last_o); end
        n_checks++; if (rd_data_o !== 4'd0 || trig_addr_o !== 4'd0) begin
            n_fail++; $display("FAIL rst_mid_read_regs got=d%0d t%0d exp=d0 t0", rd_data_o, trig_addr_o); end
        rst = 1'b0;
        tick();
        n_checks++; if (rd_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_no_resume got=%b exp=0", rd_valid_o); end
        rd_req_i = 1'b0;
        arm(4'd4);
        wait_state(3'd2, ok);
        fire_trigger();
        wait_state(3'd4, ok);
        n_checks++; if (!ok || trig_addr_o !== 4'd4) begin n_fail++; $display("FAIL rearm_trig_addr got=%0d exp=4", trig_addr_o); end
        collect(16);
        for (int k = 0; k < 16; k++) begin
            e = trig_val - 4'd4 + 4'(k);
            n_checks++; if (cap_valid[k] !== 1'b1 || cap_data[k] !== e || cap_last[k] !== (k == 15)) begin
                n_fail++; $display("FAIL rearm_sample_%0d got=v%b d%0d l%b exp=v1 d%0d l%0d", k, cap_valid[k], cap_data[k], cap_last[k], e, (k == 15)); end
        end
    endtask

`ifdef DBG_CAP_TRIG_CNT_EN
    task automatic test_trig_cnt();
        bit ok;
        logic [3:0] e;
        trig_cnt_i = 8'd2;
        arm(4'd4);
        n_checks++; if (trig_hits_o !== 8'd0) begin n_fail++; $display("FAIL tcnt_hits_on_arm got=%0d exp=0", trig_hits_o); end
        wait_state(3'd2, ok);
        for (int p = 0; p < 3; p++) begin
            fire_trigger();
            if (p < 2) begin
                n_checks++; if (state_o !== 3'd2) begin n_fail++; $display("FAIL tcnt_early_fire_%0d got=%0d exp=2", p, state_o); end
                tick();
                tick();
            end
        end
        n_checks++; if (state_o !== 3'd3 || trig_hits_o !== 8'd3) begin
            n_fail++; $display("FAIL tcnt_third got=s%0d h%0d exp=s3 h3", state_o, trig_hits_o); end
        wait_state(3'd4, ok);
        n_checks++; if (!ok || trig_addr_o !== 4'd10) begin n_fail++; $display("FAIL tcnt_trig_addr got=%0d exp=10", trig_addr_o); end
        collect(16);
        for (int k = 0; k < 16; k++) begin
            e = trig_val - 4'd4 + 4'(k);
            n_checks++; if (cap_valid[k] !== 1'b1 || cap_data[k] !== e) begin
                n_fail++; $display("FAIL tcnt_sample_%0d got=v%b d%0d exp=v1 d%0d", k, cap_valid[k], cap_data[k], e); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_window();
        test_pre_zero();
        test_wrap();
        test_abort();
        test_gating_and_reset();
`ifdef DBG_CAP_TRIG_CNT_EN
        test_trig_cnt();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
